// File: rtl/bayer_mosaic_encoder.sv
// Bayer mosaic encoder: turns a raster stream of 24-bit RGB pixels into an
// 8-bit Bayer RAW stream. Each pixel keeps only one colour channel, and the
// sensor CFA layout picks which one. Frame flags (sof/eol/eof) travel with
// each sample. A single output register gives latency 1 and full throughput.

module bayer_mosaic_encoder #(
  parameter int IMG_WIDTH  = 2,
  parameter int IMG_HEIGHT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] rgb_pixel,
  input  logic        rgb_valid,
  output logic        rgb_ready,
  input  logic [1:0]  sensor_pattern,
  output logic [7:0]  raw_pixel,
  output logic        raw_valid,
  input  logic        raw_ready,
  output logic        raw_sof,
  output logic        raw_eol,
  output logic        raw_eof,
  output logic [7:0]  frame_count
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  typedef enum logic [1:0] {
    CH_R,
    CH_G,
    CH_B
  } channel_t;

  state_t           state;
  state_t           state_next;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_next;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] row_next;
  logic [1:0]       pattern_q;
  logic [1:0]       pattern_next;
  logic [1:0]       pattern_eff;
  logic             in_fire;
  logic             out_fire;
  logic             at_first;
  logic             at_last_col;
  logic             at_last_row;
  logic             at_last;
  logic             phase_row;
  logic             phase_col;
  channel_t         channel;
  logic [7:0]       sample;

  // The output slot is free when empty or when its sample leaves this cycle.
  assign rgb_ready = !raw_valid || raw_ready;

  assign in_fire  = rgb_valid && rgb_ready;
  assign out_fire = raw_valid && raw_ready;

  assign at_first    = (col == '0) && (row == '0);
  assign at_last_col = (col == COL_LAST);
  assign at_last_row = (row == ROW_LAST);
  assign at_last     = at_last_col && at_last_row;

  // The first pixel of a frame uses the live pattern; the rest use the latched one.
  assign pattern_eff = at_first ? sensor_pattern : pattern_q;

  // CFA site lookup: pattern bit 0 shifts the tile by one column, bit 1 by one row.
  always_comb begin
    channel   = CH_G;
    phase_row = row[0] ^ pattern_eff[1];
    phase_col = col[0] ^ pattern_eff[0];
    case ({phase_row, phase_col})
      2'b00:   channel = CH_R;
      2'b01:   channel = CH_G;
      2'b10:   channel = CH_G;
      default: channel = CH_B;
    endcase
  end

  // Channel extraction is a plain byte copy, with no arithmetic on pixel data.
  always_comb begin
    sample = rgb_pixel[15:8];
    case (channel)
      CH_R:    sample = rgb_pixel[23:16];
      CH_B:    sample = rgb_pixel[7:0];
      default: sample = rgb_pixel[15:8];
    endcase
  end

  // Frame-state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame-state transitions: enter ACTIVE at the first pixel, leave at the last.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_fire && at_first) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (in_fire && at_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Raster position advance and pattern capture, driven only by accepted inputs.
  always_comb begin
    col_next     = col;
    row_next     = row;
    pattern_next = pattern_q;
    if (in_fire) begin
      if (at_first) begin
        pattern_next = sensor_pattern;
      end
      if (at_last_col) begin
        col_next = '0;
        if (at_last_row) begin
          row_next = '0;
        end else begin
          row_next = row + ROW_W'(1);
        end
      end else begin
        col_next = col + COL_W'(1);
      end
    end
  end

  // Position counters and latched pattern registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col       <= '0;
      row       <= '0;
      pattern_q <= 2'b00;
    end else begin
      col       <= col_next;
      row       <= row_next;
      pattern_q <= pattern_next;
    end
  end

  // Output register: load on input transfer, drain when taken, hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_valid <= 1'b0;
      raw_pixel <= 8'h00;
      raw_sof   <= 1'b0;
      raw_eol   <= 1'b0;
      raw_eof   <= 1'b0;
    end else if (in_fire) begin
      raw_valid <= 1'b1;
      raw_pixel <= sample;
      raw_sof   <= at_first;
      raw_eol   <= at_last_col;
      raw_eof   <= at_last;
    end else if (out_fire) begin
      raw_valid <= 1'b0;
    end
  end

  // Completed-frame counter, counted when the end-of-frame sample leaves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= 8'h00;
    end else if (out_fire && raw_eof) begin
      frame_count <= frame_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_bayer_mosaic_encoder.sv
// Self-checking bench for bayer_mosaic_encoder: one 2x2 instance and one 4x2
// instance, a raster/CFA-table reference model checked every cycle, and
// directed frames with hand-computed expected sample sequences.

module tb_bayer_mosaic_encoder;

  logic        clk;
  logic        reset_n;
  logic [23:0] rgb_pixel      [2];
  logic        rgb_valid      [2];
  logic [1:0]  sensor_pattern [2];
  logic        raw_ready      [2];

  logic        rgb_ready_v   [2];
  logic [7:0]  raw_pixel_v   [2];
  logic        raw_valid_v   [2];
  logic        raw_sof_v     [2];
  logic        raw_eol_v     [2];
  logic        raw_eof_v     [2];
  logic [7:0]  frame_count_v [2];

  logic        rgb_ready_a, rgb_ready_b;
  logic [7:0]  raw_pixel_a, raw_pixel_b;
  logic        raw_valid_a, raw_valid_b;
  logic        raw_sof_a, raw_sof_b;
  logic        raw_eol_a, raw_eol_b;
  logic        raw_eof_a, raw_eof_b;
  logic [7:0]  frame_count_a, frame_count_b;

  int total;
  int bad;

  logic [10:0] obs0[$];
  logic [10:0] obs1[$];

  logic        m_valid [2];
  logic [7:0]  m_pix   [2];
  logic        m_sof   [2];
  logic        m_eol   [2];
  logic        m_eof   [2];
  logic [1:0]  m_pat   [2];
  int          m_k     [2];
  int          m_fc    [2];

  bayer_mosaic_encoder #(.IMG_WIDTH(2), .IMG_HEIGHT(2)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .rgb_pixel(rgb_pixel[0]), .rgb_valid(rgb_valid[0]), .rgb_ready(rgb_ready_a),
    .sensor_pattern(sensor_pattern[0]),
    .raw_pixel(raw_pixel_a), .raw_valid(raw_valid_a), .raw_ready(raw_ready[0]),
    .raw_sof(raw_sof_a), .raw_eol(raw_eol_a), .raw_eof(raw_eof_a),
    .frame_count(frame_count_a)
  );

  bayer_mosaic_encoder #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .rgb_pixel(rgb_pixel[1]), .rgb_valid(rgb_valid[1]), .rgb_ready(rgb_ready_b),
    .sensor_pattern(sensor_pattern[1]),
    .raw_pixel(raw_pixel_b), .raw_valid(raw_valid_b), .raw_ready(raw_ready[1]),
    .raw_sof(raw_sof_b), .raw_eol(raw_eol_b), .raw_eof(raw_eof_b),
    .frame_count(frame_count_b)
  );

  assign rgb_ready_v[0]   = rgb_ready_a;
  assign rgb_ready_v[1]   = rgb_ready_b;
  assign raw_pixel_v[0]   = raw_pixel_a;
  assign raw_pixel_v[1]   = raw_pixel_b;
  assign raw_valid_v[0]   = raw_valid_a;
  assign raw_valid_v[1]   = raw_valid_b;
  assign raw_sof_v[0]     = raw_sof_a;
  assign raw_sof_v[1]     = raw_sof_b;
  assign raw_eol_v[0]     = raw_eol_a;
  assign raw_eol_v[1]     = raw_eol_b;
  assign raw_eof_v[0]     = raw_eof_a;
  assign raw_eof_v[1]     = raw_eof_b;
  assign frame_count_v[0] = frame_count_a;
  assign frame_count_v[1] = frame_count_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int width_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic byte site_letter(input logic [1:0] pat, input int r, input int c);
    string t;
    case (pat)
      2'd0:    t = "RGGB";
      2'd1:    t = "GRBG";
      2'd2:    t = "GBRG";
      default: t = "BGGR";
    endcase
    return t[r * 2 + c];
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference model: pixel index within the frame, CFA lookup table, frame tally.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        m_valid[d] = 1'b0;
        m_pix[d]   = 8'h00;
        m_sof[d]   = 1'b0;
        m_eol[d]   = 1'b0;
        m_eof[d]   = 1'b0;
        m_pat[d]   = 2'b00;
        m_k[d]     = 0;
        m_fc[d]    = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int w;
        int r;
        int c;
        logic in_x;
        logic out_x;
        byte ch;
        logic [23:0] px;
        w     = width_of(d);
        in_x  = rgb_valid[d] && (!m_valid[d] || raw_ready[d]);
        out_x = m_valid[d] && raw_ready[d];
        if (out_x && m_eof[d]) m_fc[d] = (m_fc[d] + 1) % 256;
        if (in_x) begin
          r = m_k[d] / w;
          c = m_k[d] % w;
          if (m_k[d] == 0) m_pat[d] = sensor_pattern[d];
          ch = site_letter(m_pat[d], r % 2, c % 2);
          px = rgb_pixel[d];
          if (ch == "R")      m_pix[d] = px[23:16];
          else if (ch == "G") m_pix[d] = px[15:8];
          else                m_pix[d] = px[7:0];
          m_sof[d]   = (m_k[d] == 0);
          m_eol[d]   = (c == w - 1);
          m_eof[d]   = (m_k[d] == w * 2 - 1);
          m_k[d]     = (m_k[d] + 1) % (w * 2);
          m_valid[d] = 1'b1;
        end else if (out_x) begin
          m_valid[d] = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("d%0d_rgb_ready", d), 32'(rgb_ready_v[d]), 32'(!m_valid[d] || raw_ready[d]));
      check_output($sformatf("d%0d_raw_valid", d), 32'(raw_valid_v[d]), 32'(m_valid[d]));
      check_output($sformatf("d%0d_frame_count", d), 32'(frame_count_v[d]), 32'(m_fc[d]));
      if (m_valid[d]) begin
        check_output($sformatf("d%0d_raw_pixel", d), 32'(raw_pixel_v[d]), 32'(m_pix[d]));
        check_output($sformatf("d%0d_raw_sof", d), 32'(raw_sof_v[d]), 32'(m_sof[d]));
        check_output($sformatf("d%0d_raw_eol", d), 32'(raw_eol_v[d]), 32'(m_eol[d]));
        check_output($sformatf("d%0d_raw_eof", d), 32'(raw_eof_v[d]), 32'(m_eof[d]));
      end
    end
  end

  // Log of output transfers as {sof, eol, eof, pixel}.
  always @(negedge clk) begin
    if (reset_n) begin
      if (raw_valid_a && raw_ready[0]) obs0.push_back({raw_sof_a, raw_eol_a, raw_eof_a, raw_pixel_a});
      if (raw_valid_b && raw_ready[1]) obs1.push_back({raw_sof_b, raw_eol_b, raw_eof_b, raw_pixel_b});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int d, input logic [23:0] px, input logic [1:0] pat);
    logic done;
    logic got;
    rgb_pixel[d]      = px;
    sensor_pattern[d] = pat;
    rgb_valid[d]      = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      got = rgb_ready_v[d];
      @(posedge clk);
      #1;
      done = got;
    end
    rgb_valid[d] = 1'b0;
    if (!done) check_output("input_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_obs0(input string tag, input int i, input logic [7:0] pix,
                            input logic sof, input logic eol, input logic eof);
    logic [10:0] e;
    e = (i < obs0.size()) ? obs0[i] : 11'h7ff;
    check_output($sformatf("%s_s%0d", tag, i), 32'(e), 32'({sof, eol, eof, pix}));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rgb_pixel[d]      = 24'h0;
      rgb_valid[d]      = 1'b0;
      sensor_pattern[d] = 2'b00;
      raw_ready[d]      = 1'b1;
    end

    idle(2);
    @(negedge clk);
    check_output("rst_rgb_ready", 32'(rgb_ready_a), 32'd1);
    check_output("rst_raw_valid", 32'(raw_valid_a), 32'd0);
    check_output("rst_raw_pixel", 32'(raw_pixel_a), 32'h00);
    check_output("rst_frame_count", 32'(frame_count_a), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_output("post_rst_rgb_ready", 32'(rgb_ready_a), 32'd1);
    idle(1);

    obs0.delete();
    for (int i = 0; i < 4; i++) apply_stimulus(0, 24'h112233, 2'd0);
    idle(3);
    check_output("rggb_count", obs0.size(), 32'd4);
    check_obs0("rggb", 0, 8'h11, 1'b1, 1'b0, 1'b0);
    check_obs0("rggb", 1, 8'h22, 1'b0, 1'b1, 1'b0);
    check_obs0("rggb", 2, 8'h22, 1'b0, 1'b0, 1'b0);
    check_obs0("rggb", 3, 8'h33, 1'b0, 1'b1, 1'b1);
    check_output("rggb_frame_count", 32'(frame_count_a), 32'd1);

    obs0.delete();
    apply_stimulus(0, 24'hFF0000, 2'd3);
    apply_stimulus(0, 24'h00FF00, 2'd0);
    apply_stimulus(0, 24'h00FF00, 2'd0);
    apply_stimulus(0, 24'h0000FF, 2'd0);
    idle(3);
    check_obs0("bggr", 0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_obs0("bggr", 1, 8'hFF, 1'b0, 1'b1, 1'b0);
    check_obs0("bggr", 2, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_obs0("bggr", 3, 8'h00, 1'b0, 1'b1, 1'b1);
    check_output("bggr_frame_count", 32'(frame_count_a), 32'd2);

    obs0.delete();
    apply_stimulus(0, 24'h112233, 2'd0);
    raw_ready[0] = 1'b0;
    rgb_pixel[0] = 24'h445566;
    rgb_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output($sformatf("bp_rgb_ready_%0d", i), 32'(rgb_ready_a), 32'd0);
      check_output($sformatf("bp_hold_pixel_%0d", i), 32'(raw_pixel_a), 32'h11);
      check_output($sformatf("bp_hold_sof_%0d", i), 32'(raw_sof_a), 32'd1);
      @(posedge clk);
      #1;
    end
    raw_ready[0] = 1'b1;
    apply_stimulus(0, 24'h445566, 2'd0);
    apply_stimulus(0, 24'h778899, 2'd0);
    apply_stimulus(0, 24'hAABBCC, 2'd0);
    idle(3);
    check_output("bp_count", obs0.size(), 32'd4);
    check_obs0("bp", 0, 8'h11, 1'b1, 1'b0, 1'b0);
    check_obs0("bp", 1, 8'h55, 1'b0, 1'b1, 1'b0);
    check_obs0("bp", 2, 8'h88, 1'b0, 1'b0, 1'b0);
    check_obs0("bp", 3, 8'hCC, 1'b0, 1'b1, 1'b1);
    check_output("bp_frame_count", 32'(frame_count_a), 32'd3);

    obs0.delete();
    for (int i = 0; i < 12; i++) apply_stimulus(0, {8'(i), 8'(i + 16), 8'(i + 32)}, 2'(i / 4));
    idle(3);
    check_output("multi_count", obs0.size(), 32'd12);
    for (int i = 0; i < 12; i++) begin
      check_output($sformatf("multi_sof_%0d", i), (i < obs0.size()) ? 32'(obs0[i][10]) : 32'hff,
                   32'((i % 4) == 0));
    end
    check_output("multi_frame_count", 32'(frame_count_a), 32'd6);

    apply_stimulus(0, 24'h112233, 2'd0);
    apply_stimulus(0, 24'h112233, 2'd0);
    apply_stimulus(0, 24'h112233, 2'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check_output("midrst_raw_valid", 32'(raw_valid_a), 32'd0);
    check_output("midrst_frame_count", 32'(frame_count_a), 32'd0);
    check_output("midrst_rgb_ready", 32'(rgb_ready_a), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    obs0.delete();
    apply_stimulus(0, 24'h010203, 2'd0);
    apply_stimulus(0, 24'h040506, 2'd0);
    apply_stimulus(0, 24'h070809, 2'd0);
    @(negedge clk);
    check_output("midrst_fc_before", 32'(frame_count_a), 32'd0);
    @(posedge clk);
    #1;
    apply_stimulus(0, 24'h0A0B0C, 2'd0);
    idle(3);
    check_obs0("midrst", 0, 8'h01, 1'b1, 1'b0, 1'b0);
    check_obs0("midrst", 1, 8'h05, 1'b0, 1'b1, 1'b0);
    check_obs0("midrst", 2, 8'h08, 1'b0, 1'b0, 1'b0);
    check_obs0("midrst", 3, 8'h0C, 1'b0, 1'b1, 1'b1);
    check_output("midrst_fc_after", 32'(frame_count_a), 32'd1);

    for (int f = 0; f < 254; f++) begin
      for (int i = 0; i < 4; i++) apply_stimulus(0, {8'(f), 8'(f + i), 8'(i)}, 2'(f % 4));
    end
    idle(3);
    check_output("wrap_255", 32'(frame_count_a), 32'd255);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 24'h123456, 2'd2);
    idle(3);
    check_output("wrap_0", 32'(frame_count_a), 32'd0);

    obs1.delete();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1, {8'(8'hA0 + i), 8'(8'hB0 + i), 8'(8'hC0 + i)}, 2'd1);
      idle(1);
    end
    idle(3);
    begin
      logic [7:0] exp_pix [8];
      exp_pix = '{8'hB0, 8'hA1, 8'hB2, 8'hA3, 8'hC4, 8'hB5, 8'hC6, 8'hB7};
      check_output("w4_count", obs1.size(), 32'd8);
      for (int i = 0; i < 8; i++) begin
        logic [10:0] e;
        e = (i < obs1.size()) ? obs1[i] : 11'h7ff;
        check_output($sformatf("w4_pix_%0d", i), 32'(e[7:0]), 32'(exp_pix[i]));
        check_output($sformatf("w4_eol_%0d", i), 32'(e[9]), 32'((i == 3) || (i == 7)));
      end
      check_output("w4_frame_count", 32'(frame_count_b), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
